// File: rtl/fsm_pp_pkg.sv
// Shared definitions for the serial-pattern practice blocks.
// Holds the 2-bit state encoding of the word feeder and the default word width
// and idle gap that the detector benches reuse.
package fsm_pp_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StShift = SHIFT,
        StGap   = GAP,
        StBad   = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultGap   = 1;

endpackage

// File: rtl/serial_word_feeder_if.sv
// Handshake and serial-output bundle of the word feeder.
//   din/din_valid/din_ready : parallel word handshake (upstream -> feeder)
//   w/w_valid               : serial bit stream and its data qualifier
//   busy/word_done          : status, word_done pulses with the last bit
// master = upstream/consumer side, slave = the feeder itself.
interface serial_word_feeder_if #(
    parameter int unsigned WIDTH = fsm_pp_pkg::DefaultWidth
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             word_done;

    modport master (
        output din, din_valid,
        input  din_ready, w, w_valid, busy, word_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, w, w_valid, busy, word_done
    );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder for the pattern detectors.
// Accepts a word on a valid/ready handshake, emits it one bit per clock on w
// (w_valid high on data cycles), then inserts GAP idle cycles of zeros.
// Ports:
//   Clk : rising-edge clock
//   Rst : asynchronous active-low reset
//   bus : serial_word_feeder_if.slave (din, din_valid, din_ready, w, w_valid,
//         busy, word_done)
module serial_word_feeder
    import fsm_pp_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = DefaultGap
) (
    input logic                 Clk,
    input logic                 Rst,
    serial_word_feeder_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [3:0] GapLast = 4'((GAP > 0) ? GAP - 1 : 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             word_done_q, word_done_d;
    // Holds din_ready low until the first edge after reset release.
    logic             rst_done_q;
    logic             din_ready;
    logic             accept;

    function automatic logic head_bit(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? (x << 1) : (x >> 1);
    endfunction

    always_comb begin
        din_ready = 1'b0;
        if (rst_done_q) begin
            if (state_q == StIdle) begin
                din_ready = 1'b1;
            end else if (GAP == 0 && state_q == StShift && bit_cnt_q == LastCnt) begin
                din_ready = 1'b1;
            end
        end
    end

    assign accept = bus.din_valid & din_ready;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        w_d         = 1'b0;
        w_valid_d   = 1'b0;
        word_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                    // First bit is registered out at the accept edge itself.
                    w_d       = head_bit(bus.din);
                    w_valid_d = 1'b1;
                    sreg_d    = drop_head(bus.din);
                end
            end
            StShift: begin
                if (bit_cnt_q != LastCnt) begin
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    w_d         = head_bit(sreg_q);
                    w_valid_d   = 1'b1;
                    word_done_d = (bit_cnt_q + 1'b1) == LastCnt;
                    sreg_d      = drop_head(sreg_q);
                end else if (GAP > 0) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end else if (accept) begin
                    bit_cnt_d = '0;
                    w_d       = head_bit(bus.din);
                    w_valid_d = 1'b1;
                    sreg_d    = drop_head(bus.din);
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d   = StIdle;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                sreg_d    = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            w_q         <= 1'b0;
            w_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            w_q         <= w_d;
            w_valid_q   <= w_valid_d;
            word_done_q <= word_done_d;
            rst_done_q  <= 1'b1;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.w         = w_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.word_done = word_done_q;
    assign bus.busy      = (state_q == StShift) || (state_q == StGap);

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: three instances cover
// MSB-first with GAP=1, MSB-first with GAP=0, and LSB-first with GAP=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_word_feeder;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_err;

    serial_word_feeder_if #(.WIDTH(8)) bus_a ();
    serial_word_feeder_if #(.WIDTH(8)) bus_b ();
    serial_word_feeder_if #(.WIDTH(8)) bus_l ();

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1)) u_dut_a (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_a)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_dut_b (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_b)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1)) u_dut_l (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_l)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reset held with din_valid high; everything must stay quiet.
    task automatic test_reset();
        Rst = 1'b0;
        bus_a.din_valid = 1'b1; bus_a.din = 8'h3C;
        bus_b.din_valid = 1'b1; bus_b.din = 8'h3C;
        bus_l.din_valid = 1'b1; bus_l.din = 8'h3C;
        repeat (3) begin
            @(negedge Clk);
            n_cmp++;
            if ({bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.din_ready,
                 bus_b.din_ready, bus_l.din_ready} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b want 000000",
                         {bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.din_ready,
                          bus_b.din_ready, bus_l.din_ready});
            end
        end
        Rst = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.din_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 0", bus_a.din_ready);
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus_a.din_ready, bus_a.busy, bus_a.w_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_first_edge: got %b want 100",
                     {bus_a.din_ready, bus_a.busy, bus_a.w_valid});
        end
        bus_a.din_valid = 1'b0;
        bus_b.din_valid = 1'b0;
        bus_l.din_valid = 1'b0;
    endtask

    task automatic test_single_word();
        logic [7:0] v;
        v = 8'h90;
        @(negedge Clk);
        bus_a.din = v; bus_a.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            bus_a.din_valid = 1'b0;
            n_cmp++;
            if ({bus_a.w, bus_a.w_valid, bus_a.word_done, bus_a.busy, bus_a.din_ready} !==
                {v[7-i], 1'b1, (i == 7), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL single_bit%0d: got %b want %b", i,
                         {bus_a.w, bus_a.w_valid, bus_a.word_done, bus_a.busy, bus_a.din_ready},
                         {v[7-i], 1'b1, (i == 7), 1'b1, 1'b0});
            end
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.din_ready} !== 4'b0010) begin
            n_err++;
            $display("FAIL single_gap: got %b want 0010",
                     {bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.din_ready});
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus_a.busy, bus_a.din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL single_idle: got %b want 01", {bus_a.busy, bus_a.din_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        s = 16'hF00F;
        @(negedge Clk);
        bus_b.din = 8'hF0; bus_b.din_valid = 1'b1;
        @(negedge Clk);
        bus_b.din = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge Clk);
            n_cmp++;
            if ({bus_b.w, bus_b.w_valid, bus_b.word_done, bus_b.din_ready} !==
                {s[15-i], 1'b1, (i == 7 || i == 15), (i == 7 || i == 15)}) begin
                n_err++;
                $display("FAIL b2b_bit%0d: got %b want %b", i,
                         {bus_b.w, bus_b.w_valid, bus_b.word_done, bus_b.din_ready},
                         {s[15-i], 1'b1, (i == 7 || i == 15), (i == 7 || i == 15)});
            end
        end
        bus_b.din_valid = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if ({bus_b.w_valid, bus_b.busy, bus_b.din_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL b2b_idle: got %b want 001",
                     {bus_b.w_valid, bus_b.busy, bus_b.din_ready});
        end
    endtask

    task automatic test_busy_stall();
        logic [15:0] s;
        s = 16'hAA55;
        @(negedge Clk);
        bus_a.din = 8'hAA; bus_a.din_valid = 1'b1;
        @(negedge Clk);
        bus_a.din = 8'h55;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge Clk);
            n_cmp++;
            if ({bus_a.w, bus_a.w_valid, bus_a.din_ready} !== {s[15-i], 2'b10}) begin
                n_err++;
                $display("FAIL stall_bit%0d: got %b want %b", i,
                         {bus_a.w, bus_a.w_valid, bus_a.din_ready}, {s[15-i], 2'b10});
            end
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus_a.w_valid, bus_a.busy, bus_a.din_ready} !== 3'b010) begin
            n_err++;
            $display("FAIL stall_gap: got %b want 010",
                     {bus_a.w_valid, bus_a.busy, bus_a.din_ready});
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus_a.w_valid, bus_a.din_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL stall_ready: got %b want 01", {bus_a.w_valid, bus_a.din_ready});
        end
        for (int i = 8; i < 16; i++) begin
            @(negedge Clk);
            bus_a.din_valid = 1'b0;
            n_cmp++;
            if ({bus_a.w, bus_a.w_valid, bus_a.word_done} !== {s[15-i], 1'b1, (i == 15)}) begin
                n_err++;
                $display("FAIL stall_second_bit%0d: got %b want %b", i - 8,
                         {bus_a.w, bus_a.w_valid, bus_a.word_done}, {s[15-i], 1'b1, (i == 15)});
            end
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] v;
        @(negedge Clk);
        bus_a.din = 8'hFF; bus_a.din_valid = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            bus_a.din_valid = 1'b0;
        end
        n_cmp++;
        if ({bus_a.w, bus_a.w_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL midreset_before: got %b want 11", {bus_a.w, bus_a.w_valid});
        end
        Rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.din_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_async: got %b want 0000",
                     {bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.din_ready});
        end
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if ({bus_a.busy, bus_a.din_ready, bus_a.w_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL midreset_idle: got %b want 010",
                     {bus_a.busy, bus_a.din_ready, bus_a.w_valid});
        end
        v = 8'h81;
        bus_a.din = v; bus_a.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            bus_a.din_valid = 1'b0;
            n_cmp++;
            if ({bus_a.w, bus_a.w_valid, bus_a.word_done} !== {v[7-i], 1'b1, (i == 7)}) begin
                n_err++;
                $display("FAIL midreset_next_bit%0d: got %b want %b", i,
                         {bus_a.w, bus_a.w_valid, bus_a.word_done}, {v[7-i], 1'b1, (i == 7)});
            end
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_lsb_first();
        logic [7:0] v;
        v = 8'h01;
        @(negedge Clk);
        bus_l.din = v; bus_l.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            bus_l.din_valid = 1'b0;
            n_cmp++;
            if ({bus_l.w, bus_l.w_valid, bus_l.word_done} !== {v[i], 1'b1, (i == 7)}) begin
                n_err++;
                $display("FAIL lsb_bit%0d: got %b want %b", i,
                         {bus_l.w, bus_l.w_valid, bus_l.word_done}, {v[i], 1'b1, (i == 7)});
            end
        end
        @(negedge Clk);
        n_cmp++;
        if ({bus_l.w_valid, bus_l.busy} !== 2'b01) begin
            n_err++;
            $display("FAIL lsb_gap: got %b want 01", {bus_l.w_valid, bus_l.busy});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_stall();
        test_reset_mid_word();
        test_lsb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage for the serial-pattern detector FSMs in Fsm_Practice.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `w`, the serial input the detector consumes.
- Inserts a programmable idle gap of zeros between words. `w_valid` marks the cycles that carry real data bits.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
- GAP, 1: idle cycles (w=0, w_valid=0) inserted after each word; legal range 0..15.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- din  input  WIDTH  parallel word to serialise.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block accepts din at this rising edge.
- w  output  1  serial data bit, registered, to detector input `w`.
- w_valid  output  1  high in cycles where w carries a data bit.
- busy  output  1  high in SHIFT or GAP.
- word_done  output  1  one-cycle pulse, coincident with the last bit of a word.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - All outputs 0 during reset.
  - din_ready goes to 1 on the first clock edge after Rst returns to 1.
  - Reset mid-word discards the word; w and w_valid drop to 0 immediately (asynchronously).
- States: IDLE, SHIFT, GAP.
- Accept condition: din_valid & din_ready at a rising edge.
- din_ready:
  - High in IDLE.
  - If GAP==0, also high in SHIFT during the last-bit cycle, so back-to-back words stream with no hole.
  - Low otherwise.
- IDLE:
  - Outputs: w=0, w_valid=0, busy=0.
  - On accept: load din into the shift register, bit counter=0, go to SHIFT.
- Latency: a word accepted at edge N shows its first bit on w in the cycle after edge N (one cycle).
- SHIFT:
  - Each cycle presents one bit; w_valid=1, busy=1.
  - Bit order follows MSB_FIRST.
  - Bit counter increments 0..WIDTH-1.
  - When counter==WIDTH-1: word_done=1.
  - Exit from the last-bit cycle:
    - GAP>0: go to GAP with gap counter=0.
    - GAP==0 and accept occurs in this cycle: reload and stay in SHIFT.
    - GAP==0 and no accept: go to IDLE.
- GAP:
  - Outputs: w=0, w_valid=0, busy=1, din_ready=0.
  - Stays GAP cycles, then goes to IDLE.
- Any din_valid while din_ready=0 is ignored. The upstream must hold din until it is accepted. din is sampled only at the accept edge.
- w, w_valid and word_done are registered outputs with no combinational path from din or din_valid. din_ready is decoded from state and counter only.
- Counter widths: bit counter $clog2(WIDTH); gap counter 4 bits.
- No wrap hazard: counters reset to 0 on every load.
- Illegal or unreachable state: return to IDLE with all outputs 0.

Decomposition:
- Shared package fsm_pp_pkg:
  - state encoding localparams IDLE=0, SHIFT=1, GAP=2 (2-bit).
  - default WIDTH and GAP constants, reused by the detector benches.
- No sub-module needed. The shift register, bit counter and gap counter live in one always block plus one next-state decode.

Test Plan:
- Reset: hold Rst=0 for 3 cycles with din_valid=1 -> w=0, w_valid=0, busy=0, din_ready=0. After release, din_ready=1 on the first edge.
- Single word, WIDTH=8, MSB_FIRST=1, GAP=1, din=0x90 ->
  - w = 1,0,0,1,0,0,0,0 on 8 consecutive w_valid=1 cycles, starting one cycle after accept.
  - word_done high on the 8th bit.
  - Then 1 GAP cycle, then din_ready=1.
- Back-to-back, GAP=0, din=0xF0 then 0x0F with din_valid held high -> 16 contiguous w_valid=1 cycles, w = 11110000 00001111, two word_done pulses 8 cycles apart.
- Busy stall: present 0xAA, then change din to 0x55 with din_valid=1 during SHIFT -> din_ready=0, output stays 10101010, 0x55 is accepted only after GAP.
- Reset mid-word: assert Rst during bit 3 of 0xFF -> w and w_valid drop to 0 immediately. After release the block is in IDLE and the next word 0x81 serialises cleanly as 1,0,0,0,0,0,0,1.
- LSB-first: MSB_FIRST=0, din=0x01 -> first bit 1, then seven 0s.
